norm_result_queue: RTL and testbench

NORM_RESULT_QUEUE -- requirements
Module: norm_result_queue

---
 rtl/norm_result_queue.sv | 136 +++++++++++++
 tb/tb_norm_result_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/norm_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : norm_result_queue
// Description : Captures norm-processor results on the rising edge of done into
//               a small FIFO and tracks the largest-magnitude norm seen.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_result_queue #(
    parameter int word_size = 24,
    parameter int len_size  = 8,
    parameter int depth     = 8,
    parameter int ptr_size  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  done,
    input  logic [len_size-1:0]   len,
    input  logic [word_size-1:0]  norm2,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [len_size-1:0]   out_len,
    output logic [word_size-1:0]  out_norm2,
    output logic [ptr_size:0]     count,
    output logic                  overflow,
    output logic [word_size-1:0]  max_norm2,
    output logic [7:0]            max_seq,
    output logic [7:0]            seq
);

    localparam logic [ptr_size-1:0] c_ptr_one   = {{(ptr_size-1){1'b0}}, 1'b1};
    localparam logic [ptr_size:0]   c_count_one = {{ptr_size{1'b0}}, 1'b1};
    localparam logic [ptr_size:0]   c_full      = depth[ptr_size:0];

    // Storage is deliberately not reset; occupancy is tracked by the pointers.
    logic [len_size-1:0]  r_mem_len  [depth];
    logic [word_size-1:0] r_mem_norm [depth];

    logic                 r_done_d;
    logic [ptr_size-1:0]  r_wr_ptr;
    logic [ptr_size-1:0]  r_rd_ptr;
    logic [ptr_size:0]    r_count;
    logic                 r_overflow;
    logic [7:0]           r_seq;
    logic [word_size-1:0] r_max_norm2;
    logic [7:0]           r_max_seq;
    logic                 r_max_valid;

    logic w_capture;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_max_update;

    assign w_full    = (r_count == c_full);
    assign w_capture = done && !r_done_d && !clear;
    assign w_pop     = (r_count != '0) && out_ready && !clear;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    // Exponent sits above the mantissa, so an unsigned compare of the low bits
    // orders by magnitude with the sign excluded.
    assign w_max_update = w_capture &&
                          (!r_max_valid ||
                           (norm2[word_size-2:0] > r_max_norm2[word_size-2:0]));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_len[r_wr_ptr]  <= len;
            r_mem_norm[r_wr_ptr] <= norm2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_d    <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_seq       <= '0;
            r_max_norm2 <= '0;
            r_max_seq   <= '0;
            r_max_valid <= 1'b0;
        end else begin
            // Edge history keeps running through clear so a held done is not re-captured.
            r_done_d <= done;
            if (clear) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_seq       <= '0;
                r_max_norm2 <= '0;
                r_max_seq   <= '0;
                r_max_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_count_one;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_count_one;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_capture) begin
                    r_seq <= r_seq + 8'd1;
                end
                if (w_max_update) begin
                    r_max_norm2 <= norm2;
                    r_max_seq   <= r_seq;
                    r_max_valid <= 1'b1;
                end
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_len   = r_mem_len[r_rd_ptr];
    assign out_norm2 = r_mem_norm[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign max_norm2 = r_max_norm2;
    assign max_seq   = r_max_seq;
    assign seq       = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_norm_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_result_queue
// Description : Directed table-driven bench for norm_result_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_result_queue;

    logic        clk;
    logic        rst_n;
    logic        done;
    logic [7:0]  len;
    logic [23:0] norm2;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_len;
    logic [23:0] out_norm2;
    logic [3:0]  count;
    logic        overflow;
    logic [23:0] max_norm2;
    logic [7:0]  max_seq;
    logic [7:0]  seq;

    int n_checks = 0;
    int n_pass   = 0;

    norm_result_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done      (done),
        .len       (len),
        .norm2     (norm2),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_len   (out_len),
        .out_norm2 (out_norm2),
        .count     (count),
        .overflow  (overflow),
        .max_norm2 (max_norm2),
        .max_seq   (max_seq),
        .seq       (seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        done;
        logic [7:0]  len;
        logic [23:0] norm2;
        logic        clear;
        logic        rdy;
        logic        e_valid;
        logic [3:0]  e_count;
        logic [7:0]  e_len;
        logic [7:0]  e_seq;
        logic        e_ovf;
        logic [23:0] e_max;
        logic [7:0]  e_mseq;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] l, input logic [23:0] n);
        done  = 1'b1;
        len   = l;
        norm2 = n;
        tick();
        done  = 1'b0;
        tick();
    endtask

    function automatic logic [23:0] mk(input logic s, input logic [7:0] e, input logic [14:0] m);
        return {s, e, m};
    endfunction

    logic [23:0] n49, e5, e6, e7, n8;

    initial begin
        n49 = 24'b0_00000110_100001001000000;
        e5  = mk(1'b0, 8'd5, 15'd0);
        e6  = mk(1'b0, 8'd6, 15'd0);
        e7  = mk(1'b0, 8'd7, 15'd0);
        n8  = mk(1'b1, 8'd8, 15'd0);

        //           done len    norm  clr rdy  v  cnt  hlen   seq ovf max  mseq
        vecs[0]  = '{1'b1, 8'd49, n49, 1'b0, 1'b0, 1'b1, 4'd1, 8'd49, 8'd1, 1'b0, n49, 8'd0};
        vecs[1]  = '{1'b1, 8'd50, e7,  1'b0, 1'b0, 1'b1, 4'd1, 8'd49, 8'd1, 1'b0, n49, 8'd0};
        vecs[2]  = '{1'b1, 8'd50, e7,  1'b0, 1'b0, 1'b1, 4'd1, 8'd49, 8'd1, 1'b0, n49, 8'd0};
        vecs[3]  = '{1'b1, 8'd50, e7,  1'b0, 1'b0, 1'b1, 4'd1, 8'd49, 8'd1, 1'b0, n49, 8'd0};
        vecs[4]  = '{1'b1, 8'd50, e7,  1'b0, 1'b0, 1'b1, 4'd1, 8'd49, 8'd1, 1'b0, n49, 8'd0};
        vecs[5]  = '{1'b0, 8'd0,  e7,  1'b0, 1'b0, 1'b1, 4'd1, 8'd49, 8'd1, 1'b0, n49, 8'd0};
        vecs[6]  = '{1'b1, 8'd77, e7,  1'b1, 1'b1, 1'b0, 4'd0, 8'd0,  8'd0, 1'b0, 24'd0, 8'd0};
        vecs[7]  = '{1'b0, 8'd0,  e7,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0,  8'd0, 1'b0, 24'd0, 8'd0};
        vecs[8]  = '{1'b1, 8'd10, e6,  1'b0, 1'b0, 1'b1, 4'd1, 8'd10, 8'd1, 1'b0, e6,  8'd0};
        vecs[9]  = '{1'b0, 8'd0,  e6,  1'b0, 1'b0, 1'b1, 4'd1, 8'd10, 8'd1, 1'b0, e6,  8'd0};
        vecs[10] = '{1'b1, 8'd11, e7,  1'b0, 1'b0, 1'b1, 4'd2, 8'd10, 8'd2, 1'b0, e7,  8'd1};
        vecs[11] = '{1'b0, 8'd0,  e7,  1'b0, 1'b0, 1'b1, 4'd2, 8'd10, 8'd2, 1'b0, e7,  8'd1};
        vecs[12] = '{1'b1, 8'd12, e6,  1'b0, 1'b0, 1'b1, 4'd3, 8'd10, 8'd3, 1'b0, e7,  8'd1};
        vecs[13] = '{1'b0, 8'd0,  e6,  1'b0, 1'b0, 1'b1, 4'd3, 8'd10, 8'd3, 1'b0, e7,  8'd1};
        vecs[14] = '{1'b1, 8'd13, e7,  1'b0, 1'b0, 1'b1, 4'd4, 8'd10, 8'd4, 1'b0, e7,  8'd1};
        vecs[15] = '{1'b0, 8'd0,  e7,  1'b0, 1'b0, 1'b1, 4'd4, 8'd10, 8'd4, 1'b0, e7,  8'd1};
        vecs[16] = '{1'b1, 8'd14, n8,  1'b0, 1'b0, 1'b1, 4'd5, 8'd10, 8'd5, 1'b0, n8,  8'd4};
        vecs[17] = '{1'b0, 8'd0,  n8,  1'b0, 1'b1, 1'b1, 4'd4, 8'd11, 8'd5, 1'b0, n8,  8'd4};
        vecs[18] = '{1'b0, 8'd0,  n8,  1'b0, 1'b1, 1'b1, 4'd3, 8'd12, 8'd5, 1'b0, n8,  8'd4};
        vecs[19] = '{1'b1, 8'd15, e5,  1'b0, 1'b1, 1'b1, 4'd3, 8'd13, 8'd6, 1'b0, n8,  8'd4};

        rst_n = 1'b0; done = 1'b0; len = '0; norm2 = '0; clear = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset_count", {28'd0, count}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_seq", {24'd0, seq}, 32'd0);
        chk("reset_max", {8'd0, max_norm2}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            done = vecs[i].done; len = vecs[i].len; norm2 = vecs[i].norm2;
            clear = vecs[i].clear; out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_count", i), {28'd0, count}, {28'd0, vecs[i].e_count});
            if (vecs[i].e_valid)
                chk($sformatf("v%0d_len", i), {24'd0, out_len}, {24'd0, vecs[i].e_len});
            chk($sformatf("v%0d_seq", i), {24'd0, seq}, {24'd0, vecs[i].e_seq});
            chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
            chk($sformatf("v%0d_max", i), {8'd0, max_norm2}, {8'd0, vecs[i].e_max});
            chk($sformatf("v%0d_mseq", i), {24'd0, max_seq}, {24'd0, vecs[i].e_mseq});
        end
        done = 1'b0; clear = 1'b0; out_ready = 1'b0;
        tick();

        // Overflow: 9 pulses into an 8-deep queue; the dropped one still wins max.
        do_clear();
        for (int i = 0; i < 9; i++) pulse(8'(i), mk(1'b0, 8'(i + 1), 15'd0));
        chk("ovf_count", {28'd0, count}, 32'd8);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_seq", {24'd0, seq}, 32'd9);
        chk("ovf_mseq", {24'd0, max_seq}, 32'd8);
        chk("ovf_max", {8'd0, max_norm2}, {8'd0, mk(1'b0, 8'd9, 15'd0)});
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_len", i), {24'd0, out_len}, 32'(i));
            chk($sformatf("drain%0d_norm", i), {8'd0, out_norm2}, {8'd0, mk(1'b0, 8'(i + 1), 15'd0)});
            tick();
        end
        chk("drain_count", {28'd0, count}, 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Full queue: capture with simultaneous pop is accepted at the tail.
        do_clear();
        for (int i = 0; i < 8; i++) pulse(8'(20 + i), e5);
        chk("full_count", {28'd0, count}, 32'd8);
        done = 1'b1; len = 8'd99; norm2 = e5; out_ready = 1'b1;
        tick();
        done = 1'b0; out_ready = 1'b0;
        chk("fullpp_count", {28'd0, count}, 32'd8);
        chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
        chk("fullpp_head", {24'd0, out_len}, 32'd21);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tail%0d_len", i), {24'd0, out_len}, (i == 7) ? 32'd99 : 32'(21 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("tail_count", {28'd0, count}, 32'd0);

        // Async reset mid-stream with done held high across release.
        pulse(8'd5, e6);
        pulse(8'd6, e7);
        done = 1'b1; len = 8'd7; norm2 = e5;
        tick();
        chk("pre_rst_count", {28'd0, count}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_count", {28'd0, count}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_seq", {24'd0, seq}, 32'd0);
        chk("arst_max", {8'd0, max_norm2}, 32'd0);
        chk("arst_mseq", {24'd0, max_seq}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("held_done_count", {28'd0, count}, 32'd1);
        chk("held_done_seq", {24'd0, seq}, 32'd1);
        chk("held_done_len", {24'd0, out_len}, 32'd7);
        done = 1'b0;
        tick();

        // Clear coinciding with a done edge suppresses the capture.
        done = 1'b1; len = 8'd33; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_edge_count", {28'd0, count}, 32'd0);
        chk("clr_edge_seq", {24'd0, seq}, 32'd0);
        tick();
        chk("clr_held_count", {28'd0, count}, 32'd0);
        done = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
